// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENG_RESET,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE,
        ST_ABORT
    } sched_state_t;

    // The engine reports a result whenever its two-bit valid field is nonzero.
    localparam logic [1:0] ENG_VALID_NONE = 2'b00;

    // One row plus the 3x3 window margin, the engine pipeline and one output register.
    function automatic int flush_cycles(input int row_size, input int eng_latency);
        return row_size + 2 + eng_latency + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer,
// pointer advances past the winner when en is high.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int PTR_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   sum;
    logic             found;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_CH)) begin
                sum = sum - (PTR_W+1)'(NUM_CH);
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (int'(winner) == NUM_CH - 1) ? '0 : winner + PTR_W'(1);
        end
    end

endmodule

// File: rtl/conv_frame_scheduler.sv
// Frame-level round-robin scheduler sharing one Laplacian engine between NUM_CH sources.
// Define CONV_SCHED_STATS_EN to add per-channel 16-bit completed-frame counters on frame_cnt.
module conv_frame_scheduler
    import conv_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int ROW_SIZE    = 540,
    parameter int FRAME_ROWS  = 540,
    parameter int NUM_CH      = 2,
    parameter int ENG_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             req,
    output logic [NUM_CH-1:0]             grant,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*WORD_SIZE-1:0]   in_pixel,
    output logic [NUM_CH-1:0]             in_ready,
    output logic                          eng_rst,
    output logic [WORD_SIZE-1:0]          eng_pixel,
    input  logic [WORD_SIZE-1:0]          eng_out_pixel,
    input  logic [1:0]                    eng_valid,
    output logic                          out_valid,
    output logic [WORD_SIZE-1:0]          out_pixel,
    output logic [$clog2(NUM_CH)-1:0]     out_ch,
    output logic                          frame_done,
    output logic                          underrun,
    output logic                          busy,
    output logic [NUM_CH*16-1:0]          frame_cnt
);

    localparam int CH_W         = $clog2(NUM_CH);
    localparam int PIX_TOTAL    = ROW_SIZE * FRAME_ROWS;
    localparam int PIX_W        = $clog2(PIX_TOTAL);
    localparam int FLUSH_CYCLES = flush_cycles(ROW_SIZE, ENG_LATENCY);
    localparam int FL_W         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(PIX_TOTAL - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

    sched_state_t          state, state_nxt;
    logic [NUM_CH-1:0]     grant_q;
    logic [NUM_CH-1:0]     arb_grant;
    logic                  arb_en;
    logic [PIX_W-1:0]      pix_cnt;
    logic [FL_W-1:0]       flush_cnt;
    logic [CH_W-1:0]       gidx;
    logic [WORD_SIZE-1:0]  sel_pixel;
    logic                  gvalid;
    logic                  result_ok;

    assign arb_en    = (state == ST_IDLE) && (req != '0);
    assign grant     = grant_q;
    assign gvalid    = |(in_valid & grant_q);
    assign result_ok = (eng_valid != ENG_VALID_NONE) &&
                       ((state == ST_STREAM) || (state == ST_FLUSH));

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .en    (arb_en),
        .grant (arb_grant)
    );

    always_comb begin
        gidx      = '0;
        sel_pixel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q[c]) begin
                gidx      = CH_W'(c);
                sel_pixel = in_pixel[c*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = '0;
        eng_pixel  = '0;
        eng_rst    = rst;
        frame_done = 1'b0;
        underrun   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (req != '0) state_nxt = ST_ENG_RESET;
            end
            ST_ENG_RESET: begin
                eng_rst   = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready  = grant_q;
                eng_pixel = sel_pixel;
                // The engine cannot stall, so a missing pixel kills the frame.
                if (!gvalid)                  state_nxt = ST_ABORT;
                else if (pix_cnt == PIX_LAST) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            ST_ABORT: begin
                eng_rst   = 1'b1;
                underrun  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            pix_cnt   <= '0;
            flush_cnt <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_ch    <= '0;
        end else begin
            state <= state_nxt;
            if (arb_en) begin
                grant_q <= arb_grant;
            end else if ((state == ST_DONE) || (state == ST_ABORT)) begin
                grant_q <= '0;
            end
            pix_cnt   <= (state == ST_STREAM) ? pix_cnt + PIX_W'(1) : '0;
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FL_W'(1) : '0;
            out_valid <= result_ok;
            if (result_ok) begin
                out_pixel <= eng_out_pixel;
                out_ch    <= gidx;
            end
        end
    end

`ifdef CONV_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                frame_cnt[c*16 +: 16] <= '0;
            end else if ((state == ST_DONE) && grant_q[c]) begin
                frame_cnt[c*16 +: 16] <= frame_cnt[c*16 +: 16] + 16'd1;
            end
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler (ROW_SIZE=8, FRAME_ROWS=4) with an output scoreboard.
module tb_conv_frame_scheduler;

    localparam int NPIX   = 8 * 4;          // pixels per frame
    localparam int NFLUSH = 8 + 2 + 3 + 1;  // flush cycles

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, grant, in_valid, in_ready, eng_valid;
    logic [15:0] in_pixel;
    logic        eng_rst;
    logic [7:0]  eng_pixel, eng_out_pixel, out_pixel;
    logic        out_valid, out_ch, frame_done, underrun, busy;
    logic [31:0] frame_cnt;

    typedef struct {
        logic [7:0] pix;
        int         ch;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_frame_scheduler #(
        .WORD_SIZE(8), .ROW_SIZE(8), .FRAME_ROWS(4), .NUM_CH(2), .ENG_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .eng_rst(eng_rst), .eng_pixel(eng_pixel), .eng_out_pixel(eng_out_pixel),
        .eng_valid(eng_valid), .out_valid(out_valid), .out_pixel(out_pixel),
        .out_ch(out_ch), .frame_done(frame_done), .underrun(underrun),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_pixels(input int ch, input logic [7:0] p);
        logic [15:0] v;
        v = {~p, ~p};
        if (ch == 0) v[7:0] = p;
        else         v[15:8] = p;
        in_pixel = v;
    endtask

    task automatic drive_eng(input logic [1:0] v, input logic [7:0] p, input int ch, input bit keep);
        eng_valid     = v;
        eng_out_pixel = p;
        if (keep) sb.push_back('{pix: p, ch: ch, cyc: cyc});
    endtask

    // Scoreboard monitor: every registered result must match the oldest expectation,
    // arriving exactly one cycle after the engine presented it.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
                check("out_ch", 32'(out_ch), 32'(mon_e.ch));
                check("out_latency", 32'(cyc), 32'(mon_e.cyc + 1));
            end
        end
    end

    // Entered at the negedge of an IDLE cycle with req set so that ch wins at the next edge.
    task automatic run_frame(input int ch, input int drop_at, input logic [1:0] req_during);
        logic [1:0] chmask;
        logic [7:0] p;
        bit         aborted;
        chmask  = (ch == 0) ? 2'b01 : 2'b10;
        aborted = 1'b0;

        @(posedge clk); #1;
        req = req_during;
        drive_eng(2'b01, 8'h5A, ch, 1'b0);
        @(negedge clk);
        check("eng_reset_grant", 32'(grant), 32'(chmask));
        check("eng_reset_eng_rst", 32'(eng_rst), 32'd1);
        check("eng_reset_eng_pixel", 32'(eng_pixel), 32'd0);
        check("eng_reset_in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < NPIX; i++) begin
            @(posedge clk); #1;
            p = 8'(i * 5 + 3 + ch * 64);
            set_pixels(ch, p);
            in_valid = (i == drop_at) ? ~chmask : 2'b11;
            if (i == 3)             drive_eng(2'b01, p ^ 8'h5A, ch, 1'b1);
            else if (i == NPIX - 1) drive_eng(2'b11, p ^ 8'hA5, ch, 1'b1);
            else                    drive_eng(2'b00, 8'h00, ch, 1'b0);
            @(negedge clk);
            if (i != drop_at) check("stream_in_ready", 32'(in_ready), 32'(chmask));
            check("stream_eng_pixel", 32'(eng_pixel), 32'(p));
            check("stream_eng_rst", 32'(eng_rst), 32'd0);
            if (i == drop_at) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            @(posedge clk); #1;
            in_valid = 2'b11;
            drive_eng(2'b01, 8'h99, ch, 1'b0);
            @(negedge clk);
            check("abort_underrun", 32'(underrun), 32'd1);
            check("abort_eng_rst", 32'(eng_rst), 32'd1);
            check("abort_frame_done", 32'(frame_done), 32'd0);
            check("abort_in_ready", 32'(in_ready), 32'd0);
        end else begin
            for (int j = 0; j < NFLUSH; j++) begin
                @(posedge clk); #1;
                set_pixels(ch, 8'hFF);
                if (j == 5)               drive_eng(2'b10, 8'hAB, ch, 1'b1);
                else if (j == NFLUSH - 1) drive_eng(2'b11, 8'hCD, ch, 1'b1);
                else                      drive_eng(2'b00, 8'h00, ch, 1'b0);
                @(negedge clk);
                check("flush_in_ready", 32'(in_ready), 32'd0);
                check("flush_eng_pixel", 32'(eng_pixel), 32'd0);
                check("flush_frame_done", 32'(frame_done), 32'd0);
                check("flush_busy", 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            drive_eng(2'b01, 8'hEE, ch, 1'b0);
            @(negedge clk);
            check("done_frame_done", 32'(frame_done), 32'd1);
            check("done_grant", 32'(grant), 32'(chmask));
            check("done_underrun", 32'(underrun), 32'd0);
        end

        @(posedge clk); #1;
        drive_eng(2'b01, 8'h77, ch, 1'b0);
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frame_done", 32'(frame_done), 32'd0);
        check("idle_underrun", 32'(underrun), 32'd0);
        check("idle_eng_rst", 32'(eng_rst), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 2'b00;
        in_valid = 2'b11;
        in_pixel = '0;
        eng_valid = 2'b00;
        eng_out_pixel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pixel", 32'(out_pixel), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eng_rst", 32'(eng_rst), 32'd1);
        check("rst_frame_cnt", frame_cnt, 32'd0);

        // Lone ch0 frame; req drops mid-frame and the frame still completes.
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b01;
        @(negedge clk);
        check("first_idle_busy", 32'(busy), 32'd0);
        run_frame(0, -1, 2'b00);

        // The result offered during the IDLE cycle must be dropped.
        @(posedge clk); #1;
        drive_eng(2'b00, 8'h00, 0, 1'b0);
        @(negedge clk);
        check("idle_result_dropped", 32'(out_valid), 32'd0);

        // ch1 underruns at pixel 10 while ch0 waits; then ch0, ch1, ch0, ch1 with req held.
        @(posedge clk); #1;
        req = 2'b10;
        @(negedge clk);
        check("pre_abort_idle", 32'(grant), 32'd0);
        run_frame(1, 10, 2'b11);
        run_frame(0, -1, 2'b11);
        run_frame(1, -1, 2'b11);
        run_frame(0, -1, 2'b11);
        run_frame(1, -1, 2'b00);

        // Synchronous reset at pixel 5 of a ch0 frame.
        @(posedge clk); #1;
        req = 2'b01;
        drive_eng(2'b00, 8'h00, 0, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_test_grant", 32'(grant), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_pixels(0, 8'(i + 1));
            if (i == 5) begin
                rst = 1'b1;
                drive_eng(2'b01, 8'h3C, 0, 1'b0);
            end
            @(negedge clk);
            if (i == 5) check("rst_mid_eng_rst", 32'(eng_rst), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive_eng(2'b00, 8'h00, 0, 1'b0);
            @(negedge clk);
            check("rst_mid_grant", 32'(grant), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_out_valid", 32'(out_valid), 32'd0);
            check("rst_mid_eng_rst", 32'(eng_rst), 32'd1);
            check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        check("post_rst_eng_rst", 32'(eng_rst), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        check("ptr_cleared_by_rst", 32'(grant), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b10;
        @(negedge clk);
        check("second_rst_grant", 32'(grant), 32'd0);

        // Three consecutive ch1 frames.
        run_frame(1, -1, 2'b10);
        run_frame(1, -1, 2'b10);
        run_frame(1, -1, 2'b00);
`ifdef CONV_SCHED_STATS_EN
        check("frame_cnt", frame_cnt, 32'h0003_0000);
`else
        check("frame_cnt", frame_cnt, 32'h0000_0000);
`endif

        @(posedge clk); #1;
        drive_eng(2'b00, 8'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
